pe_residue_scheduler: RTL
=========================

# pe_residue_scheduler

Clocked scheduler that shares one threshold/residue unit among `NUM_REQ` partial-sum producers inside a PE and keeps per-neuron membrane residue across a timestep sequence. Each accepted request carries a partial sum and a target neuron id. The block accumulates that sum into the stored residue, thresholds it, writes back the remainder and emits a spike token. It sits between the PE's MAC lanes and the PE output packetizer.

## Interface
- `WIDTH`, 8: residue / partial-sum width (unsigned).
- `THRESHOLD`, 64: firing threshold; fire when accumulated value is strictly greater.
- `NUM_REQ`, 4: number of requesters.
- `NUM_NEURONS`, 4: neurons tracked; must be a power of 2, `NID_W = log2(NUM_NEURONS)` (min 1).
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NUM_REQ  per-requester valid.
- `req_data`  in  NUM_REQ*WIDTH  partial sums; requester i at bits [i*WIDTH +: WIDTH].
- `req_nid`  in  NUM_REQ*NID_W  target neuron ids, packed the same way.
- `req_ready`  out  NUM_REQ  one-hot grant/ready.
- `clear`  in  1  single-cycle pulse: zero all residues (new inference).
- `spk_valid`  out  1  spike token valid.
- `spk_ready`  in  1  consumer ready.
- `spk_out`  out  1  1 = neuron fired.
- `spk_nid`  out  NID_W  neuron id of token.
- `res_out`  out  WIDTH  residue written back.
- `busy`  out  1  high in CALC or EMIT.

## Operation
- FSM states: IDLE, CALC, EMIT.
- IDLE, `clear` or clear_pending set: zero all residues, drop clear_pending, drive no `req_ready` this cycle.
- IDLE otherwise: round-robin arbiter picks the first valid requester starting at pointer `rr`. Asserts `req_ready[g]` combinationally; only one bit is ever high. Handshake = valid & ready. On the edge: latch data/nid, `rr <= g+1` (mod NUM_REQ), go to CALC.
- With no valid requester, IDLE holds and `rr` is unchanged.
- CALC: `sum = residue[nid] + data` computed in WIDTH+1 bits, saturated to 2^WIDTH-1.
  - If `sum > THRESHOLD`: `spk_out=1`, new residue = `sum - THRESHOLD`.
  - Else: `spk_out=0`, new residue = `sum`.
  - On the edge: write residue, register `spk_out`/`spk_nid`/`res_out`, set `spk_valid`, go to EMIT.
- EMIT: hold `spk_valid` and all token outputs stable until `spk_ready`. On the handshake edge: clear `spk_valid`, go to IDLE.
- `clear` arriving in CALC or EMIT sets clear_pending; it never aborts the in-flight request. The CALC write-back still occurs, then is zeroed on return to IDLE.
- Requests are serialized, so back-to-back requests to the same neuron always see the updated residue.

## Timing
- Reset (async, immediate): state IDLE, residues 0, `rr` 0, clear_pending 0. `req_ready` 0, `spk_valid` 0, `spk_out` 0, `spk_nid` 0, `res_out` 0, `busy` 0.
- Handshake in cycle c gives CALC in c+1 and `spk_valid` high from c+2.
- With `spk_ready` held high: token accepted in c+2, IDLE in c+3, next grant possible in c+3. Throughput is one request per 3 cycles.
- `req_ready` is low in CALC and EMIT; requesters must hold valid/data.
- `spk_out`, `spk_nid` and `res_out` retain their last values after the EMIT handshake until the next CALC.
- `rst_n` low mid-operation discards the in-flight request; no token is emitted.

## Test plan
- Reset, req0 data=70 nid=1 -> `spk_valid` 2 cycles after handshake; spk_out=1, spk_nid=1, res_out=6.
- Two requests to nid 2: data=64 -> spk_out=0, res_out=64. Then data=1 -> spk_out=1, res_out=1.
- All four `req_valid` held high for 5 grants -> grant order 0,1,2,3,0; exactly one `req_ready` bit per IDLE cycle.
- Saturation: nid 3 data=60 (res 60), then data=250 -> sum saturates at 255, spk_out=1, res_out=191.
- `spk_ready` low for 5 cycles in EMIT, with `clear` pulsed during EMIT -> outputs stable and no `req_ready`. Then nid 1 data=10 -> res_out=10, showing the pending clear applied.
- `rst_n` pulsed low during CALC -> all outputs 0 immediately, no token emitted. Afterwards nid 1 data=5 -> res_out=5.

Source files
------------

// File: rtl/pe_residue_scheduler.sv
// Shares one accumulate/threshold unit among NUM_REQ partial-sum producers and
// keeps per-neuron membrane residue between timesteps.
module pe_residue_scheduler #(
    parameter int WIDTH       = 8,
    parameter int THRESHOLD   = 64,
    parameter int NUM_REQ     = 4,
    parameter int NUM_NEURONS = 4,
    localparam int NID_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    input  logic [NUM_REQ*NID_W-1:0]   req_nid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       clear,
    output logic                       spk_valid,
    input  logic                       spk_ready,
    output logic                       spk_out,
    output logic [NID_W-1:0]           spk_nid,
    output logic [WIDTH-1:0]           res_out,
    output logic                       busy
);
    localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] EMIT = 2'd2;
    localparam logic [WIDTH:0] SAT_MAX = {1'b0, {WIDTH{1'b1}}};
    // A threshold at or above the saturation ceiling can never be exceeded.
    localparam logic [WIDTH:0] THR = (THRESHOLD >= (2**WIDTH)) ? SAT_MAX : (WIDTH+1)'(THRESHOLD);

    logic [1:0]                        state;
    logic [RR_W-1:0]                   rr;
    logic                              clear_pending;
    logic [NUM_NEURONS-1:0][WIDTH-1:0] residue;
    logic [WIDTH-1:0]                  lat_data;
    logic [NID_W-1:0]                  lat_nid;

    logic            found;
    logic [RR_W-1:0] gnt_idx;
    logic [RR_W-1:0] idx;
    logic [RR_W-1:0] rr_next;
    logic            idle_clear;
    logic            take;
    logic [WIDTH-1:0] sel_data;
    logic [NID_W-1:0] sel_nid;

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = RR_W'((int'(rr) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    assign idle_clear = clear | clear_pending;
    assign take       = (state == IDLE) && !idle_clear && found;
    assign req_ready  = take ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign rr_next    = (gnt_idx == RR_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
    assign sel_data   = req_data[int'(gnt_idx)*WIDTH +: WIDTH];
    assign sel_nid    = req_nid[int'(gnt_idx)*NID_W +: NID_W];
    assign busy       = (state != IDLE);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   sat;
    logic [WIDTH:0]   diff;
    logic             fire;
    logic [WIDTH-1:0] new_res;

    always_comb begin
        sum     = {1'b0, residue[lat_nid]} + {1'b0, lat_data};
        sat     = sum[WIDTH] ? SAT_MAX : sum;
        fire    = (sat > THR);
        diff    = sat - THR;
        new_res = fire ? diff[WIDTH-1:0] : sat[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr            <= '0;
            clear_pending <= 1'b0;
            residue       <= '0;
            lat_data      <= '0;
            lat_nid       <= '0;
            spk_valid     <= 1'b0;
            spk_out       <= 1'b0;
            spk_nid       <= '0;
            res_out       <= '0;
        end else begin
            // A clear during an in-flight request is deferred until IDLE.
            if (clear && state != IDLE) clear_pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (idle_clear) begin
                        residue       <= '0;
                        clear_pending <= 1'b0;
                    end else if (found) begin
                        lat_data <= sel_data;
                        lat_nid  <= sel_nid;
                        rr       <= rr_next;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    residue[lat_nid] <= new_res;
                    spk_out          <= fire;
                    spk_nid          <= lat_nid;
                    res_out          <= new_res;
                    spk_valid        <= 1'b1;
                    state            <= EMIT;
                end
                EMIT: begin
                    if (spk_ready) begin
                        spk_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
